// File: rtl/uncachable_access_arbiter_if.sv
// Bundle of the requester, uncachable-memory and IO-strobe signals around
// the uncachable access arbiter. The master modport is the arbiter itself;
// the slave modport is everything around it (requesters, memory, IO).
interface uncachable_access_arbiter_if;
    // Requester 0
    logic        req0_valid;
    logic        req0_isStore;
    logic [21:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req0_ready;
    logic        resp0_valid;
    logic        resp0_err;
    logic [31:0] resp0_rdata;
    // Requester 1
    logic        req1_valid;
    logic        req1_isStore;
    logic [21:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_ready;
    logic        resp1_valid;
    logic        resp1_err;
    logic [31:0] resp1_rdata;
    // Uncachable memory port
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_isStore;
    logic [19:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    // IO strobe port
    logic        io_valid;
    logic        io_isStore;
    logic [19:0] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (
        input  req0_valid, req0_isStore, req0_addr, req0_wdata,
        input  req1_valid, req1_isStore, req1_addr, req1_wdata,
        output req0_ready, resp0_valid, resp0_err, resp0_rdata,
        output req1_ready, resp1_valid, resp1_err, resp1_rdata,
        output mem_req_valid, mem_req_isStore, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output io_valid, io_isStore, io_addr, io_wdata,
        input  io_rdata
    );

    modport slave (
        output req0_valid, req0_isStore, req0_addr, req0_wdata,
        output req1_valid, req1_isStore, req1_addr, req1_wdata,
        input  req0_ready, resp0_valid, resp0_err, resp0_rdata,
        input  req1_ready, resp1_valid, resp1_err, resp1_rdata,
        input  mem_req_valid, mem_req_isStore, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  io_valid, io_isStore, io_addr, io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/uncachable_access_arbiter.sv
// Two-requester round-robin arbiter for uncachable accesses. One access is
// outstanding at a time; it is routed either to the uncachable memory port
// (with a response timeout) or to the single-cycle IO strobe, and completes
// with a one-cycle response pulse to the granted requester.
module uncachable_access_arbiter #(
    parameter int unsigned MEM_TIMEOUT = 255  // 1..255 cycles in MEM_WAIT
) (
    input  logic                          clk,
    input  logic                          rst,
    uncachable_access_arbiter_if.master   bus
);

    typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, IO_ACC, RESP} stateT;

    // Last MEM_WAIT counter value: the counter starts at 0 on entry, so this
    // bounds the stay in MEM_WAIT to exactly MEM_TIMEOUT cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hCCCC_CCCC;

    stateT       state;
    stateT       nextState;
    logic        rrPtr;       // preferred requester when both are valid
    logic        grantId;     // requester owning the outstanding access
    logic        latIsStore;
    logic [19:0] latAddr;
    logic [31:0] latWdata;
    logic [7:0]  waitCnt;
    logic        respErr;
    logic [31:0] respData;

    logic        grantValid;
    logic        grantSel;
    logic [21:0] grantAddr;
    logic        respHit0;
    logic        respHit1;

    // Round-robin pick among pending requesters; only meaningful in IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        grantSel = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grantSel = rrPtr;
        end else if (bus.req1_valid) begin
            grantSel = 1'b1;
        end
        grantValid = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
        grantAddr  = grantSel ? bus.req1_addr : bus.req0_addr;
    end

    // Next-state decode for the access sequence.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (grantValid) begin
                    if (grantAddr[20]) begin
                        nextState = IO_ACC;
                    end else if (grantAddr[21]) begin
                        nextState = MEM_REQ;
                    end else begin
                        nextState = RESP;   // cachable address: error reply
                    end
                end
            end
            MEM_REQ: begin
                if (bus.mem_req_ready) begin
                    nextState = latIsStore ? RESP : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_resp_valid || (waitCnt == TIMEOUT_LAST)) begin
                    nextState = RESP;
                end
            end
            IO_ACC:  nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register plus the latched request and pending response fields.
    always_ff @(posedge clk) begin
        // NOTE: data registers are reset as well as control, because the
        // bus outputs are driven straight from them and must read 0 in reset.
        if (rst) begin
            state      <= IDLE;
            rrPtr      <= 1'b0;
            grantId    <= 1'b0;
            latIsStore <= 1'b0;
            latAddr    <= '0;
            latWdata   <= '0;
            waitCnt    <= '0;
            respErr    <= 1'b0;
            respData   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before this clock edge.
            state <= nextState;
            unique case (state)
                IDLE: begin
                    if (grantValid) begin
                        grantId    <= grantSel;
                        latIsStore <= grantSel ? bus.req1_isStore : bus.req0_isStore;
                        latAddr    <= grantAddr[19:0];
                        latWdata   <= grantSel ? bus.req1_wdata : bus.req0_wdata;
                        respErr    <= !grantAddr[20] && !grantAddr[21];
                        respData   <= '0;
                    end
                end
                MEM_REQ: begin
                    waitCnt <= '0;
                    if (bus.mem_req_ready) begin
                        respErr  <= 1'b0;
                        respData <= '0;
                    end
                end
                MEM_WAIT: begin
                    waitCnt <= waitCnt + 8'd1;
                    if (bus.mem_resp_valid) begin
                        respErr  <= 1'b0;
                        respData <= bus.mem_resp_data;
                    end else if (waitCnt == TIMEOUT_LAST) begin
                        respErr  <= 1'b1;
                        respData <= TIMEOUT_DATA;
                    end
                end
                IO_ACC: begin
                    respErr  <= 1'b0;
                    respData <= latIsStore ? 32'd0 : bus.io_rdata;
                end
                RESP: begin
                    rrPtr <= ~grantId;
                end
                default: ;
            endcase
        end
    end

    assign respHit0 = (state == RESP) && (grantId == 1'b0);
    assign respHit1 = (state == RESP) && (grantId == 1'b1);

    assign bus.req0_ready  = grantValid && !grantSel;
    assign bus.req1_ready  = grantValid && grantSel;

    assign bus.resp0_valid = respHit0;
    assign bus.resp0_err   = respHit0 && respErr;
    assign bus.resp0_rdata = respHit0 ? respData : 32'd0;
    assign bus.resp1_valid = respHit1;
    assign bus.resp1_err   = respHit1 && respErr;
    assign bus.resp1_rdata = respHit1 ? respData : 32'd0;

    assign bus.mem_req_valid   = (state == MEM_REQ);
    assign bus.mem_req_isStore = latIsStore;
    assign bus.mem_req_addr    = latAddr;
    assign bus.mem_req_wdata   = latWdata;

    assign bus.io_valid   = (state == IO_ACC);
    assign bus.io_isStore = latIsStore;
    assign bus.io_addr    = latAddr;
    assign bus.io_wdata   = latWdata;

endmodule

// File: tb/tb_uncachable_access_arbiter.sv
// Directed bench for the uncachable access arbiter. Stimulus pushes the
// expected responses, IO strobes and memory requests into queues; a monitor
// on the falling edge pops and compares whenever the DUT presents one.
module tb_uncachable_access_arbiter;

    typedef struct {
        logic        id;
        logic        err;
        logic [31:0] rdata;
    } respT;

    typedef struct {
        logic        isStore;
        logic [19:0] addr;
        logic [31:0] wdata;
    } busT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nCompared   = 0;
    int   nMismatched = 0;

    respT respQ[$];
    busT  ioQ[$];
    busT  memQ[$];

    uncachable_access_arbiter_if bus ();

    uncachable_access_arbiter #(.MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input logic id, input logic v, input logic st,
                          input logic [21:0] a, input logic [31:0] wd);
        if (id == 1'b0) begin
            bus.req0_valid = v; bus.req0_isStore = st; bus.req0_addr = a; bus.req0_wdata = wd;
        end else begin
            bus.req1_valid = v; bus.req1_isStore = st; bus.req1_addr = a; bus.req1_wdata = wd;
        end
    endtask

    // Wait (bounded) for the grant pulse of requester id, then drop its valid.
    task automatic waitGrant(input logic id);
        logic got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            #1;
            if ((id == 1'b0) ? bus.req0_ready : bus.req1_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check($sformatf("grant seen req%0d", id), 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (id == 1'b0) bus.req0_valid = 1'b0;
        else            bus.req1_valid = 1'b0;
    endtask

    task automatic issue(input logic id, input logic st, input logic [21:0] a,
                         input logic [31:0] wd);
        setReq(id, 1'b1, st, a, wd);
        waitGrant(id);
    endtask

    // Let the DUT run until every expected response has been seen.
    task automatic drain(input int budget);
        int n = 0;
        while ((respQ.size() != 0) && (n < budget)) begin
            tick();
            n++;
        end
        check("responses pending", 32'(respQ.size()), 32'd0);
    endtask

    function automatic respT mkResp(input logic id, input logic err, input logic [31:0] d);
        respT r;
        r.id = id; r.err = err; r.rdata = d;
        return r;
    endfunction

    function automatic busT mkBus(input logic st, input logic [19:0] a, input logic [31:0] d);
        busT b;
        b.isStore = st; b.addr = a; b.wdata = d;
        return b;
    endfunction

    // Scoreboard monitor, sampling half a cycle away from the active edge.
    respT monResp;
    busT  monBus;
    always @(negedge clk) begin
        if (bus.resp0_valid || bus.resp1_valid) begin
            if (respQ.size() == 0) begin
                check("stray resp", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
            end else begin
                monResp = respQ.pop_front();
                check("resp target", 32'({bus.resp1_valid, bus.resp0_valid}),
                      monResp.id ? 32'd2 : 32'd1);
                check("resp err", 32'(monResp.id ? bus.resp1_err : bus.resp0_err),
                      32'(monResp.err));
                check("resp rdata", monResp.id ? bus.resp1_rdata : bus.resp0_rdata,
                      monResp.rdata);
            end
        end
        if (bus.io_valid) begin
            if (ioQ.size() == 0) begin
                check("stray io_valid", 32'(bus.io_valid), 32'd0);
            end else begin
                monBus = ioQ.pop_front();
                check("io_isStore", 32'(bus.io_isStore), 32'(monBus.isStore));
                check("io_addr", 32'(bus.io_addr), 32'(monBus.addr));
                check("io_wdata", bus.io_wdata, monBus.wdata);
            end
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            if (memQ.size() == 0) begin
                check("stray mem_req", 32'(bus.mem_req_valid), 32'd0);
            end else begin
                monBus = memQ.pop_front();
                check("mem_req_isStore", 32'(bus.mem_req_isStore), 32'(monBus.isStore));
                check("mem_req_addr", 32'(bus.mem_req_addr), 32'(monBus.addr));
                check("mem_req_wdata", bus.mem_req_wdata, monBus.wdata);
            end
        end
    end

    task automatic checkAllZero(input string tag);
        check({tag, " req ready"}, 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        check({tag, " resp valid"}, 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
        check({tag, " resp err"}, 32'({bus.resp1_err, bus.resp0_err}), 32'd0);
        check({tag, " resp0_rdata"}, bus.resp0_rdata, 32'd0);
        check({tag, " resp1_rdata"}, bus.resp1_rdata, 32'd0);
        check({tag, " mem/io valid"}, 32'({bus.mem_req_valid, bus.io_valid}), 32'd0);
        check({tag, " mem_req_addr"}, 32'(bus.mem_req_addr), 32'd0);
        check({tag, " mem_req_wdata"}, bus.mem_req_wdata, 32'd0);
        check({tag, " io_addr"}, 32'(bus.io_addr), 32'd0);
        check({tag, " io_wdata"}, bus.io_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        setReq(1'b0, 1'b0, 1'b0, 22'd0, 32'd0);
        setReq(1'b1, 1'b0, 1'b0, 22'd0, 32'd0);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'd0;
        bus.io_rdata       = 32'h1234_5678;
        rst = 1'b1;
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b0;
        tick();

        // Both requesters issue IO loads; rr pointer 0 grants req0 first.
        ioQ.push_back(mkBus(1'b0, 20'h0_0004, 32'd0));
        ioQ.push_back(mkBus(1'b0, 20'h0_0004, 32'd0));
        respQ.push_back(mkResp(1'b0, 1'b0, 32'h1234_5678));
        respQ.push_back(mkResp(1'b1, 1'b0, 32'h1234_5678));
        setReq(1'b0, 1'b1, 1'b0, 22'h10_0004, 32'd0);
        setReq(1'b1, 1'b1, 1'b0, 22'h10_0004, 32'd0);
        #1;
        check("both valid: req0_ready", 32'(bus.req0_ready), 32'd1);
        check("both valid: req1_ready", 32'(bus.req1_ready), 32'd0);
        tick();                               // T+1
        bus.req0_valid = 1'b0;
        check("io strobe at T+1", 32'(bus.io_valid), 32'd1);
        check("req1 pending at T+1", 32'(bus.req1_ready), 32'd0);
        tick();                               // T+2
        check("resp0 at T+2", 32'(bus.resp0_valid), 32'd1);
        check("req1 pending at T+2", 32'(bus.req1_ready), 32'd0);
        tick();                               // back in IDLE
        waitGrant(1'b1);
        drain(20);

        // req1 uncachable load: ready held off 3 cycles, data 2 cycles later.
        memQ.push_back(mkBus(1'b0, 20'h1_0040, 32'd0));
        respQ.push_back(mkResp(1'b1, 1'b0, 32'hDEAD_BEEF));
        issue(1'b1, 1'b0, 22'h21_0040, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("mem_req_valid held", 32'(bus.mem_req_valid), 32'd1);
            check("mem_req_addr stable", 32'(bus.mem_req_addr), 32'h1_0040);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        tick();                               // MEM_WAIT, first cycle
        bus.mem_req_ready = 1'b0;
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hDEAD_BEEF;
        tick();
        bus.mem_resp_valid = 1'b0;
        drain(20);

        // req0 uncachable load with no response: timeout error.
        memQ.push_back(mkBus(1'b0, 20'h0_0100, 32'd0));
        respQ.push_back(mkResp(1'b0, 1'b1, 32'hCCCC_CCCC));
        issue(1'b0, 1'b0, 22'h20_0100, 32'd0);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        drain(20);
        // Late response after the timeout must be dropped silently.
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hBAD0_BAD0;
        tick();
        bus.mem_resp_valid = 1'b0;
        tick();
        check("late resp dropped", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
        tick();

        // Response in the last allowed MEM_WAIT cycle (4th with timeout 4)
        // wins over the timeout.
        memQ.push_back(mkBus(1'b0, 20'h0_0180, 32'd0));
        respQ.push_back(mkResp(1'b1, 1'b0, 32'h5555_AAAA));
        issue(1'b1, 1'b0, 22'h20_0180, 32'd0);
        bus.mem_req_ready = 1'b1;
        tick();                               // MEM_WAIT cycle 1
        bus.mem_req_ready = 1'b0;
        tick();
        tick();
        tick();                               // MEM_WAIT cycle 4
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h5555_AAAA;
        tick();
        bus.mem_resp_valid = 1'b0;
        drain(20);

        // Cachable address: immediate error, no memory or IO activity.
        respQ.push_back(mkResp(1'b0, 1'b1, 32'd0));
        issue(1'b0, 1'b0, 22'h00_1000, 32'd0);
        check("cachable resp at T+1", 32'(bus.resp0_valid), 32'd1);
        check("cachable no mem/io", 32'({bus.mem_req_valid, bus.io_valid}), 32'd0);
        drain(20);

        // Serial store through IO: store data on the strobe, rdata 0.
        ioQ.push_back(mkBus(1'b1, 20'h0_2000, 32'h0000_0041));
        respQ.push_back(mkResp(1'b1, 1'b0, 32'd0));
        issue(1'b1, 1'b1, 22'h30_2000, 32'h0000_0041);
        drain(20);

        // Store to memory with ready already high: response at T+2.
        memQ.push_back(mkBus(1'b1, 20'h0_0200, 32'hA5A5_0001));
        respQ.push_back(mkResp(1'b0, 1'b0, 32'd0));
        bus.mem_req_ready = 1'b1;
        issue(1'b0, 1'b1, 22'h20_0200, 32'hA5A5_0001);
        tick();
        check("mem store resp at T+2", 32'(bus.resp0_valid), 32'd1);
        bus.mem_req_ready = 1'b0;
        drain(20);

        // rr pointer now prefers req1; reset in MEM_WAIT must clear it.
        memQ.push_back(mkBus(1'b0, 20'h0_0300, 32'd0));
        issue(1'b0, 1'b0, 22'h20_0300, 32'd0);
        bus.mem_req_ready = 1'b1;
        tick();                               // MEM_WAIT
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        checkAllZero("mid-access reset");
        rst = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h1111_1111;
        tick();
        bus.mem_resp_valid = 1'b0;
        tick();
        check("no resp after reset", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
        respQ.push_back(mkResp(1'b0, 1'b1, 32'd0));
        respQ.push_back(mkResp(1'b1, 1'b1, 32'd0));
        setReq(1'b0, 1'b1, 1'b0, 22'h00_0000, 32'd0);
        setReq(1'b1, 1'b1, 1'b0, 22'h00_0000, 32'd0);
        #1;
        check("rr reset: req0_ready", 32'(bus.req0_ready), 32'd1);
        check("rr reset: req1_ready", 32'(bus.req1_ready), 32'd0);
        waitGrant(1'b0);
        waitGrant(1'b1);
        drain(20);

        tick();
        check("io strobes pending", 32'(ioQ.size()), 32'd0);
        check("mem requests pending", 32'(memQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/uncachable_access_arbiter.md
UNCACHABLE_ACCESS_ARBITER -- requirements
Module: uncachable_access_arbiter

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, SHALL set the max cycles spent in MEM_WAIT before an error response (range 1..255).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high; ports are clk and rst.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 reqN_valid  in  1  requester N (N=0,1) has an access pending.
REQ-006 reqN_isStore  in  1  1=store, 0=load.
REQ-007 reqN_addr  in  22  physical address {isUncachable, isIO, raw[19:0]}.
REQ-008 reqN_wdata  in  32  store data.
REQ-009 reqN_ready  out  1  grant/accept pulse for requester N.
REQ-010 respN_valid  out  1  one-cycle completion pulse to requester N.
REQ-011 respN_err  out  1  completion is an error (valid with respN_valid).
REQ-012 respN_rdata  out  32  load data (valid with respN_valid).
REQ-013 mem_req_valid / mem_req_ready  out / in  1 / 1  uncachable memory request handshake.
REQ-014 mem_req_isStore, mem_req_addr, mem_req_wdata  out  1, 20, 32  latched request fields.
REQ-015 mem_resp_valid, mem_resp_data  in  1, 32  memory load response.
REQ-016 io_valid, io_isStore, io_addr, io_wdata  out  1, 1, 20, 32  single-cycle IO strobe (timer/serial).
REQ-017 io_rdata  in  32  IO read data, valid combinationally in the io_valid cycle.

Function
REQ-018 FSM states: IDLE, MEM_REQ, MEM_WAIT, IO_ACC, RESP; one access outstanding at a time.
REQ-019 IDLE: if any reqN_valid, grant one requester; reqN_ready=1 for that cycle only; latch isStore, addr, wdata, grantee id.
REQ-020 Arbitration: round-robin; rr pointer names the preferred requester; a lone valid requester is granted regardless of the pointer.
REQ-021 Both valid in IDLE: grant requester == rr pointer; the other stays pending (reqN_ready=0).
REQ-022 After grant: isIO=1 -> IO_ACC; isIO=0, isUncachable=1 -> MEM_REQ; isIO=0, isUncachable=0 (cachable, illegal here) -> RESP with err=1, rdata=0.
REQ-023 IO_ACC: io_valid=1 for exactly one cycle with latched fields; loads capture io_rdata that cycle; -> RESP.
REQ-024 MEM_REQ: mem_req_valid held 1 with stable fields until mem_req_ready=1; store -> RESP on handshake; load -> MEM_WAIT.
REQ-025 MEM_WAIT: 8-bit counter cleared on entry, +1 per cycle; mem_resp_valid=1 -> capture mem_resp_data, -> RESP err=0.
REQ-026 MEM_WAIT timeout: counter reaching MEM_TIMEOUT without mem_resp_valid -> RESP with err=1, rdata=32'hCCCC_CCCC; mem_resp_valid in that same cycle has priority (normal completion).
REQ-027 mem_resp_valid outside MEM_WAIT SHALL be ignored (late responses after timeout are dropped).
REQ-028 RESP: respN_valid=1 for one cycle to the grantee only, with err/rdata; no back-pressure; rr pointer <- other requester; -> IDLE.
REQ-029 New grant earliest the cycle after RESP; reqN_ready never asserted outside IDLE.
REQ-030 Latency (grant cycle T): IO access resp at T+2; store to mem with immediate ready resp at T+2; load to mem with ready at T+1, data at T+2 -> resp at T+3.
REQ-031 respN_rdata for stores SHALL be 0.

Reset
REQ-032 rst=1 SHALL force state IDLE, rr pointer=0, counter=0, all valid/ready/err outputs 0, data/addr outputs 0.
REQ-033 rst mid-access SHALL abandon the access without response; subsequent stray mem_resp_valid ignored.

Verification
REQ-034 Both requesters assert IO loads at addr {0,1,20'h00004} after reset -> req0_ready first, io_valid next cycle, resp0_valid with io_rdata one cycle later; then req1 granted.
REQ-035 req1 uncachable load addr {1,0,20'h1_0040}, mem_req_ready delayed 3 cycles, mem_resp 2 cycles later data 32'hDEAD_BEEF -> resp1_valid, err=0, rdata 32'hDEAD_BEEF.
REQ-036 Uncachable load, MEM_TIMEOUT=4, no mem_resp -> resp err=1, rdata 32'hCCCC_CCCC; later mem_resp_valid produces no response.
REQ-037 Cachable address {0,0,20'h0_1000} request -> resp err=1, rdata 0, no mem_req_valid/io_valid.
REQ-038 rst pulsed in MEM_WAIT -> all outputs 0 next cycle, no respN_valid, rr pointer 0.
REQ-039 Serial store {1,1,20'h0_2000} data 8'h41 -> single io_valid with io_isStore=1, io_wdata 32'h41, then resp pulse err=0.
